// File: rtl/fpga_uart_pkg.sv
// fpga_uart shared types and divisor helpers.
// Optional frame_err output is enabled by UART_FRAMING_ERR_EN.
package fpga_uart_pkg;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   localparam int unsigned DEF_CLK_FREQ = 50_000_000;
   localparam int unsigned DEF_BAUD     = 115_200;
   localparam int unsigned OVERSAMPLE   = 16;

   function automatic int unsigned clks_per_bit(
      input int unsigned clk_freq,
      input int unsigned baud
   );
      return clk_freq / baud;
   endfunction

   function automatic int unsigned clks_per_sample(
      input int unsigned clk_freq,
      input int unsigned baud
   );
      return clk_freq / (baud * OVERSAMPLE);
   endfunction

endpackage

// File: rtl/fpga_uart_baud_gen.sv
// Bit-rate and 16x sample-rate tick generator.
// Each divider has its own synchronous restart.
module fpga_uart_baud_gen #(
   parameter int unsigned CPB = 434,
   parameter int unsigned CPS = 27
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tx_restart,
   input  logic rx_restart,
   output logic tx_tick,
   output logic rx_tick
);

   localparam int TW = (CPB > 1) ? $clog2(CPB) : 1;
   localparam int RW = (CPS > 1) ? $clog2(CPS) : 1;

   logic [TW-1:0] tx_cnt;
   logic [RW-1:0] rx_cnt;

   assign tx_tick = (tx_cnt == TW'(CPB - 1));
   assign rx_tick = (rx_cnt == RW'(CPS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_cnt <= '0;
      end else if (tx_restart || tx_tick) begin
         tx_cnt <= '0;
      end else begin
         tx_cnt <= tx_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_cnt <= '0;
      end else if (rx_restart || rx_tick) begin
         rx_cnt <= '0;
      end else begin
         rx_cnt <= rx_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/fpga_uart.sv
// Full-duplex 8N1 UART: baud generator, transmitter, 16x receiver.
// Define UART_FRAMING_ERR_EN to add the frame_err output.
module fpga_uart
   import fpga_uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
   parameter int unsigned BAUD     = DEF_BAUD
) (
   input  logic       clk_50m,
   input  logic       rst_n,
   input  logic [7:0] data_in,
   input  logic       Tx_en,
   output logic       Tx,
   output logic       Tx_busy,
   input  logic       Rx,
   input  logic       Rx_en,
   output logic       ready,
   input  logic       ready_clr,
   output logic [7:0] data_out
`ifdef UART_FRAMING_ERR_EN
   ,
   output logic       frame_err
`endif
);

   localparam int unsigned CLKS_PER_BIT    = clks_per_bit(CLK_FREQ, BAUD);
   localparam int unsigned CLKS_PER_SAMPLE = clks_per_sample(CLK_FREQ, BAUD);

   logic tx_tick;
   logic rx_tick;
   logic tx_accept;
   logic rx_start_edge;

   fpga_uart_baud_gen #(
      .CPB(CLKS_PER_BIT),
      .CPS(CLKS_PER_SAMPLE)
   ) u_baud (
      .clk       (clk_50m),
      .rst_n     (rst_n),
      .tx_restart(tx_accept),
      .rx_restart(rx_start_edge),
      .tx_tick   (tx_tick),
      .rx_tick   (rx_tick)
   );

   // Transmitter
   tx_state_t  tx_state;
   tx_state_t  tx_next;
   logic [7:0] tx_shift;
   logic [2:0] tx_bit;

   assign tx_accept = (tx_state == TX_IDLE) && Tx_en;

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) tx_state <= TX_IDLE;
      else        tx_state <= tx_next;
   end

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         tx_shift <= '0;
         tx_bit   <= '0;
      end else if (tx_accept) begin
         tx_shift <= data_in;
         tx_bit   <= '0;
      end else if (tx_state == TX_DATA && tx_tick) begin
         tx_shift <= {1'b0, tx_shift[7:1]};
         tx_bit   <= tx_bit + 3'd1;
      end
   end

   always_comb begin
      tx_next = tx_state;
      unique case (tx_state)
         TX_IDLE:  if (Tx_en) tx_next = TX_START;
         TX_START: if (tx_tick) tx_next = TX_DATA;
         TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = TX_STOP;
         TX_STOP:  if (tx_tick) tx_next = TX_IDLE;
         default:  tx_next = TX_IDLE;
      endcase
   end

   always_comb begin
      Tx      = 1'b1;
      Tx_busy = (tx_state != TX_IDLE);
      unique case (tx_state)
         TX_START: Tx = 1'b0;
         TX_DATA:  Tx = tx_shift[0];
         default:  Tx = 1'b1;
      endcase
   end

   // Receiver
   logic       rx_meta;
   logic       rx_s;
   rx_state_t  rx_state;
   rx_state_t  rx_next;
   logic [3:0] samp_cnt;
   logic [2:0] rx_bit;
   logic [7:0] rx_shift;
   logic       armed;
   logic       start_mid;
   logic       bit_mid;
   logic       good_stop;
   logic       bad_stop;
   logic       frame_end;

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= Rx;
         rx_s    <= rx_meta;
      end
   end

   assign rx_start_edge = (rx_state == RX_IDLE) && armed && !rx_s;
   assign start_mid     = rx_tick && (samp_cnt == 4'd7);
   assign bit_mid       = rx_tick && (samp_cnt == 4'd15);

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) rx_state <= RX_IDLE;
      else        rx_state <= rx_next;
   end

   always_comb begin
      rx_next = rx_state;
      unique case (rx_state)
         RX_IDLE:  if (rx_start_edge) rx_next = RX_START;
         RX_START: if (start_mid) rx_next = rx_s ? RX_IDLE : RX_DATA;
         RX_DATA:  if (bit_mid && rx_bit == 3'd7) rx_next = RX_STOP;
         RX_STOP:  if (bit_mid) rx_next = RX_IDLE;
         default:  rx_next = RX_IDLE;
      endcase
   end

   always_comb begin
      frame_end = (rx_state == RX_STOP) && bit_mid;
      good_stop = frame_end && rx_s;
      bad_stop  = frame_end && !rx_s;
   end

   // Counter realigns to the start-bit midpoint, then wraps every 16 ticks
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         samp_cnt <= '0;
      end else if (rx_start_edge || (rx_state == RX_START && start_mid)) begin
         samp_cnt <= '0;
      end else if (rx_tick && rx_state != RX_IDLE) begin
         samp_cnt <= samp_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         rx_shift <= '0;
         rx_bit   <= '0;
      end else if (rx_start_edge) begin
         rx_bit   <= '0;
      end else if (rx_state == RX_DATA && bit_mid) begin
         rx_shift <= {rx_s, rx_shift[7:1]};
         rx_bit   <= rx_bit + 3'd1;
      end
   end

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         armed    <= 1'b0;
         ready    <= 1'b0;
         data_out <= '0;
      end else begin
         if (Rx_en)          armed <= 1'b1;
         else if (frame_end) armed <= 1'b0;
         if (good_stop)      ready <= 1'b1;
         else if (ready_clr) ready <= 1'b0;
         if (good_stop)      data_out <= rx_shift;
      end
   end

`ifdef UART_FRAMING_ERR_EN
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n)                      frame_err <= 1'b0;
      else if (bad_stop)               frame_err <= 1'b1;
      else if (ready_clr || good_stop) frame_err <= 1'b0;
   end
`else
   logic unused_bad_stop;
   assign unused_bad_stop = bad_stop;
`endif

endmodule

// File: tb/tb_fpga_uart.sv
// Directed self-checking bench for fpga_uart.
// Build with UART_FRAMING_ERR_EN to also check frame_err.
module tb_fpga_uart;

   localparam int CPB = 434;

   logic       clk_50m = 1'b0;
   logic       rst_n;
   logic [7:0] data_in;
   logic       Tx_en;
   logic       Tx;
   logic       Tx_busy;
   logic       Rx;
   logic       Rx_en;
   logic       ready;
   logic       ready_clr;
   logic [7:0] data_out;
`ifdef UART_FRAMING_ERR_EN
   logic       frame_err;
`endif

   logic loop;
   logic rx_drv;
   int   n_tests = 0;
   int   n_fail  = 0;

   assign Rx = loop ? Tx : rx_drv;

   always #10 clk_50m = ~clk_50m;

   fpga_uart dut (
      .clk_50m  (clk_50m),
      .rst_n    (rst_n),
      .data_in  (data_in),
      .Tx_en    (Tx_en),
      .Tx       (Tx),
      .Tx_busy  (Tx_busy),
      .Rx       (Rx),
      .Rx_en    (Rx_en),
      .ready    (ready),
      .ready_clr(ready_clr),
      .data_out (data_out)
`ifdef UART_FRAMING_ERR_EN
      ,
      .frame_err(frame_err)
`endif
   );

   task automatic check(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_and_watch(
      input logic [7:0] b,
      input int         inj_at,
      input logic [7:0] inj
   );
      logic [9:0] got;
      int         busy_cnt;
      got      = '1;
      busy_cnt = 0;
      @(negedge clk_50m);
      data_in = b;
      Tx_en   = 1'b1;
      @(negedge clk_50m);
      Tx_en   = 1'b0;
      for (int i = 0; i < 6000; i++) begin
         if (i == inj_at) begin
            data_in = inj;
            Tx_en   = 1'b1;
         end
         if (i == inj_at + 1) Tx_en = 1'b0;
         if ((i % CPB) == CPB / 2 && (i / CPB) < 10) got[i/CPB] = Tx;
         if (!Tx_busy) break;
         busy_cnt++;
         @(negedge clk_50m);
      end
      check("tx_frame", {22'd0, got}, {22'd0, 1'b1, b, 1'b0});
      check("tx_busy_len", busy_cnt, 4340);
      repeat (5) @(negedge clk_50m);
      check("tx_no_queue", {31'd0, Tx_busy}, 32'd0);
      check("tx_idle_high", {31'd0, Tx}, 32'd1);
   endtask

   task automatic drive_rx(input logic [7:0] b, input logic stop);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      for (int k = 0; k < 10; k++) begin
         rx_drv = bits[k];
         repeat (CPB) @(negedge clk_50m);
      end
      rx_drv = 1'b1;
      repeat (20) @(negedge clk_50m);
   endtask

   task automatic pulse_rx_en();
      @(negedge clk_50m);
      Rx_en = 1'b1;
      @(negedge clk_50m);
      Rx_en = 1'b0;
   endtask

   task automatic pulse_clr();
      @(negedge clk_50m);
      ready_clr = 1'b1;
      @(negedge clk_50m);
      ready_clr = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      data_in   = '0;
      Tx_en     = 1'b0;
      Rx_en     = 1'b0;
      ready_clr = 1'b0;
      loop      = 1'b0;
      rx_drv    = 1'b1;
      repeat (5) @(negedge clk_50m);
      check("rst_tx", {31'd0, Tx}, 32'd1);
      check("rst_busy", {31'd0, Tx_busy}, 32'd0);
      check("rst_ready", {31'd0, ready}, 32'd0);
      check("rst_data", {24'd0, data_out}, 32'd0);
`ifdef UART_FRAMING_ERR_EN
      check("rst_ferr", {31'd0, frame_err}, 32'd0);
`endif
      rst_n = 1'b1;
      repeat (5) @(negedge clk_50m);

      // Loopback of three bytes
      loop = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_50m);
         data_in = 8'(k);
         Tx_en   = 1'b1;
         Rx_en   = 1'b1;
         @(negedge clk_50m);
         Tx_en   = 1'b0;
         Rx_en   = 1'b0;
         check("lb_start_low", {31'd0, Tx}, 32'd0);
         check("lb_busy", {31'd0, Tx_busy}, 32'd1);
         for (int i = 0; i < 5000 && !ready; i++) @(negedge clk_50m);
         check("lb_ready", {31'd0, ready}, 32'd1);
         check("lb_data", {24'd0, data_out}, k);
         pulse_clr();
         check("lb_clr", {31'd0, ready}, 32'd0);
         for (int i = 0; i < 1000 && Tx_busy; i++) @(negedge clk_50m);
         check("lb_tx_done", {31'd0, Tx_busy}, 32'd0);
      end
      loop = 1'b0;
      repeat (10) @(negedge clk_50m);

      send_and_watch(8'hA5, -1, 8'h00);
      send_and_watch(8'h3C, 1000, 8'hFF);

      // Receiver must ignore a frame while disarmed
      drive_rx(8'h55, 1'b1);
      check("rx_disarmed_rdy", {31'd0, ready}, 32'd0);
      check("rx_disarmed_dat", {24'd0, data_out}, 32'h02);
      pulse_rx_en();
      drive_rx(8'h55, 1'b1);
      check("rx_armed_rdy", {31'd0, ready}, 32'd1);
      check("rx_armed_dat", {24'd0, data_out}, 32'h55);

      pulse_clr();
      check("rx_clr", {31'd0, ready}, 32'd0);
      pulse_rx_en();
      drive_rx(8'h81, 1'b0);
      check("bad_stop_rdy", {31'd0, ready}, 32'd0);
      check("bad_stop_dat", {24'd0, data_out}, 32'h55);
`ifdef UART_FRAMING_ERR_EN
      check("bad_stop_ferr", {31'd0, frame_err}, 32'd1);
      pulse_clr();
      check("ferr_clr", {31'd0, frame_err}, 32'd0);
`endif

      // Reset in the middle of data bit 4
      @(negedge clk_50m);
      data_in = 8'h5A;
      Tx_en   = 1'b1;
      @(negedge clk_50m);
      Tx_en   = 1'b0;
      repeat (CPB * 5 + CPB / 2) @(negedge clk_50m);
      check("pre_rst_busy", {31'd0, Tx_busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_tx", {31'd0, Tx}, 32'd1);
      check("mid_rst_busy", {31'd0, Tx_busy}, 32'd0);
      check("mid_rst_data", {24'd0, data_out}, 32'd0);
      @(negedge clk_50m);
      rst_n = 1'b1;
      repeat (3) @(negedge clk_50m);
      send_and_watch(8'hC3, -1, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
